// File: rtl/banked_pixel_buffer_if.sv
// Write-stream, swap and dual read-port bundle for banked_pixel_buffer.
// The master side is the block loader / SAD consumer; the buffer is the slave.
interface banked_pixel_buffer_if #(
  parameter int DWIDTH = 8,
  parameter int BLK_W  = 16,
  parameter int BLK_H  = 16,
  parameter int BX     = 2,
  parameter int BY     = 2
);
  localparam int NB  = BX * BY;
  localparam int QAW = $clog2(BLK_W * BLK_H / NB);
  localparam int PAW = $clog2(BLK_W * BLK_H);

  logic                   wr_valid;
  logic                   wr_ready;
  logic [DWIDTH-1:0]      wr_data;
  logic                   swap;
  logic                   load_full;
  logic                   front_valid;
  logic [QAW-1:0]         addr_a;
  logic [NB*DWIDTH-1:0]   quad_data;
  logic [PAW-1:0]         addr_b;
  logic [DWIDTH-1:0]      pix_data;

  modport master (
    output wr_valid, wr_data, swap, addr_a, addr_b,
    input  wr_ready, load_full, front_valid, quad_data, pix_data
  );

  modport slave (
    input  wr_valid, wr_data, swap, addr_a, addr_b,
    output wr_ready, load_full, front_valid, quad_data, pix_data
  );
endinterface

// File: rtl/banked_pixel_buffer.sv
// Double-buffered, BX x BY bank-interleaved pixel block store with a raster
// write stream, a neighbourhood (quad) read port and a single-pixel read port.
module bpb_bank #(
  parameter int DWIDTH = 8,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  output logic [DWIDTH-1:0] qa,
  output logic [DWIDTH-1:0] qb
);
  logic [DWIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Storage is left unreset; only the read registers clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      qa <= '0;
      qb <= '0;
    end else begin
      qa <= mem[ra];
      qb <= mem[rb];
    end
endmodule

module banked_pixel_buffer #(
  parameter int DWIDTH = 8,
  parameter int BLK_W  = 16,
  parameter int BLK_H  = 16,
  parameter int BX     = 2,
  parameter int BY     = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  banked_pixel_buffer_if.slave bus
);
  localparam int NB    = BX * BY;
  localparam int NPIX  = BLK_W * BLK_H;
  localparam int DEPTH = NPIX / NB;
  localparam int QAW   = $clog2(DEPTH);
  localparam int PAW   = $clog2(NPIX);
  localparam int KW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW    = QAW + 1;

  typedef struct packed {
    logic [KW-1:0]  bank;
    logic [QAW-1:0] word;
  } loc_t;

  typedef enum logic {LOADING, FULL} bstate_e;

  // Raster index -> (bank, word); all divisors are powers of 2 so this is wiring.
  function automatic loc_t decode(input logic [PAW-1:0] a);
    int x, y;
    loc_t l;
    x = int'(a) % BLK_W;
    y = int'(a) / BLK_W;
    l.bank = KW'((y % BY) * BX + (x % BX));
    l.word = QAW'((y / BY) * (BLK_W / BX) + x / BX);
    return l;
  endfunction

  bstate_e        state_q, state_d;
  logic           front_sel, front_sel_d;
  logic           front_valid, front_valid_d;
  logic [PAW-1:0] p, p_d;
  logic           wr_fire;
  logic [KW-1:0]  bsel_q;
  loc_t           wloc, bloc;

  logic [NB-1:0][DWIDTH-1:0] qa, qb;
  logic [NB*DWIDTH-1:0]      quad;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= LOADING;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      p           <= '0;
      bsel_q      <= '0;
    end else begin
      state_q     <= state_d;
      front_sel   <= front_sel_d;
      front_valid <= front_valid_d;
      p           <= p_d;
      bsel_q      <= bloc.bank;
    end

  // Swap only acts from FULL, so a held or early swap pulse is a no-op.
  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel;
    front_valid_d = front_valid;
    p_d           = p;
    wr_fire       = 1'b0;
    case (state_q)
      LOADING: if (bus.wr_valid) begin
        wr_fire = 1'b1;
        p_d     = p + 1'b1;
        if (p == PAW'(NPIX - 1)) state_d = FULL;
      end
      FULL: if (bus.swap) begin
        state_d       = LOADING;
        front_sel_d   = ~front_sel;
        front_valid_d = 1'b1;
      end
      default: state_d = LOADING;
    endcase
  end

  assign wloc = decode(p);
  assign bloc = decode(bus.addr_b);

  for (genvar k = 0; k < NB; k++) begin : g_bank
    bpb_bank #(.DWIDTH(DWIDTH), .AW(AW)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_fire && (wloc.bank == KW'(k))),
      .waddr ({~front_sel, wloc.word}),
      .wdata (bus.wr_data),
      .ra    ({front_sel, bus.addr_a}),
      .rb    ({front_sel, bloc.word}),
      .qa    (qa[k]),
      .qb    (qb[k])
    );
  end

  // Bank 0 lands in the MSBs of the quad word.
  always_comb begin
    quad = '0;
    for (int k = 0; k < NB; k++)
      quad[(NB-k)*DWIDTH-1 -: DWIDTH] = qa[k];
  end

  assign bus.quad_data   = quad;
  assign bus.pix_data    = qb[bsel_q];
  assign bus.wr_ready    = (state_q == LOADING);
  assign bus.load_full   = (state_q == FULL);
  assign bus.front_valid = front_valid;
endmodule

// File: tb/tb_banked_pixel_buffer.sv
// Directed bench for banked_pixel_buffer: load/swap, both read ports,
// ping-pong, backpressure and mid-load reset.
module tb_banked_pixel_buffer;
  localparam int DW = 8, BW = 16, BH = 16, BXP = 2, BYP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  banked_pixel_buffer_if #(.DWIDTH(DW), .BLK_W(BW), .BLK_H(BH), .BX(BXP), .BY(BYP)) bus ();

  banked_pixel_buffer #(.DWIDTH(DW), .BLK_W(BW), .BLK_H(BH), .BX(BXP), .BY(BYP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pval(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(255 - i);
      2:       return 8'(i) ^ 8'h5A;
      3:       return 8'h77;
      default: return 8'(i + 3);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input int mode, input bit throttle, input int start, input int nbeats);
    int idx, cyc;
    bit acc;
    idx = start;
    cyc = 0;
    while (idx < start + nbeats && cyc < 4000) begin
      bus.wr_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.wr_data  = pval(mode, idx);
      acc = bus.wr_valid && bus.wr_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bus.wr_valid = 1'b0;
    n_checks++;
    if (idx !== start + nbeats) begin
      n_fail++;
      $display("FAIL load_beats: accepted %0d required %0d", idx - start, nbeats);
    end
  endtask

  task automatic test_reset();
    bus.wr_valid = 0; bus.wr_data = 0; bus.swap = 0; bus.addr_a = 0; bus.addr_b = 0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.load_full !== 1'b0) begin n_fail++; $display("FAIL rst_load_full: got %b want 0", bus.load_full); end
    n_checks++; if (bus.front_valid !== 1'b0) begin n_fail++; $display("FAIL rst_front_valid: got %b want 0", bus.front_valid); end
    n_checks++; if (bus.quad_data !== 32'h0) begin n_fail++; $display("FAIL rst_quad: got %h want 0", bus.quad_data); end
    n_checks++; if (bus.pix_data !== 8'h0) begin n_fail++; $display("FAIL rst_pix: got %h want 0", bus.pix_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_load_swap();
    load_block(0, 1'b0, 0, 255);
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_before_last: got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.load_full !== 1'b0) begin n_fail++; $display("FAIL full_before_last: got %b want 0", bus.load_full); end
    load_block(0, 1'b0, 255, 1);
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL ready_after_last: got %b want 0", bus.wr_ready); end
    n_checks++; if (bus.load_full !== 1'b1) begin n_fail++; $display("FAIL full_after_last: got %b want 1", bus.load_full); end
    n_checks++; if (bus.front_valid !== 1'b0) begin n_fail++; $display("FAIL fv_before_swap: got %b want 0", bus.front_valid); end
    // Writes offered while full must be dropped silently.
    bus.wr_valid = 1'b1; bus.wr_data = 8'hCC;
    repeat (3) tick();
    bus.wr_valid = 1'b0;
    n_checks++; if (bus.load_full !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %b want 1", bus.load_full); end
    bus.swap = 1'b1;
    tick();
    n_checks++; if (bus.front_valid !== 1'b1) begin n_fail++; $display("FAIL fv_after_swap: got %b want 1", bus.front_valid); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_swap: got %b want 1", bus.wr_ready); end
    tick(); tick();
    bus.swap = 1'b0;
    n_checks++; if (bus.load_full !== 1'b0) begin n_fail++; $display("FAIL full_after_held_swap: got %b want 0", bus.load_full); end
  endtask

  task automatic test_pixel_read();
    bus.addr_b = 8'h13;
    tick();
    n_checks++; if (bus.pix_data !== 8'h13) begin n_fail++; $display("FAIL pix_13: got %h want 13", bus.pix_data); end
    for (int i = 0; i < 256; i++) begin
      bus.addr_b = 8'(i);
      tick();
      n_checks++;
      if (bus.pix_data !== 8'(i)) begin n_fail++; $display("FAIL pix_sweep: addr %h got %h want %h", i, bus.pix_data, 8'(i)); end
    end
  endtask

  task automatic test_quad_read();
    bus.addr_a = 7'd5;
    tick();
    n_checks++; if (bus.quad_data !== 32'h0A0B1A1B) begin n_fail++; $display("FAIL quad_5: got %h want 0a0b1a1b", bus.quad_data); end
    bus.addr_a = 7'd63;
    tick();
    n_checks++; if (bus.quad_data !== 32'hEEEFFEFF) begin n_fail++; $display("FAIL quad_63: got %h want eeeffeff", bus.quad_data); end
    bus.addr_a = 7'd0;
    tick();
    n_checks++; if (bus.quad_data !== 32'h00011011) begin n_fail++; $display("FAIL quad_0: got %h want 00011011", bus.quad_data); end
    // Both ports on bank 0 word 5 in the same cycle.
    bus.addr_a = 7'd5; bus.addr_b = 8'h0A;
    tick();
    n_checks++; if (bus.quad_data !== 32'h0A0B1A1B) begin n_fail++; $display("FAIL quad_shared: got %h want 0a0b1a1b", bus.quad_data); end
    n_checks++; if (bus.pix_data !== 8'h0A) begin n_fail++; $display("FAIL pix_shared: got %h want 0a", bus.pix_data); end
  endtask

  task automatic test_ping_pong();
    fork
      load_block(1, 1'b0, 0, 256);
      for (int i = 0; i < 256; i++) begin
        bus.addr_b = 8'(i * 7 + 3);
        tick();
        n_checks++;
        if (bus.pix_data !== 8'(i * 7 + 3)) begin n_fail++; $display("FAIL pp_front_read: got %h want %h", bus.pix_data, 8'(i * 7 + 3)); end
      end
    join
    n_checks++; if (bus.load_full !== 1'b1) begin n_fail++; $display("FAIL pp_full: got %b want 1", bus.load_full); end
    bus.addr_b = 8'h20; bus.addr_a = 7'd0;
    tick();
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    n_checks++; if (bus.pix_data !== 8'h20) begin n_fail++; $display("FAIL pp_swap_edge_pix: got %h want 20", bus.pix_data); end
    n_checks++; if (bus.quad_data !== 32'h00011011) begin n_fail++; $display("FAIL pp_swap_edge_quad: got %h want 00011011", bus.quad_data); end
    tick();
    n_checks++; if (bus.pix_data !== 8'hDF) begin n_fail++; $display("FAIL pp_after_swap_pix: got %h want df", bus.pix_data); end
    n_checks++; if (bus.quad_data !== 32'hFFFEEFEE) begin n_fail++; $display("FAIL pp_after_swap_quad: got %h want fffeefee", bus.quad_data); end
    n_checks++; if (bus.load_full !== 1'b0) begin n_fail++; $display("FAIL pp_empty_back: got %b want 0", bus.load_full); end
    // Swap with an empty back buffer must not move the front.
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    tick();
    n_checks++; if (bus.pix_data !== 8'hDF) begin n_fail++; $display("FAIL pp_idle_swap_pix: got %h want df", bus.pix_data); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL pp_idle_swap_ready: got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.front_valid !== 1'b1) begin n_fail++; $display("FAIL pp_idle_swap_fv: got %b want 1", bus.front_valid); end
  endtask

  task automatic test_backpressure();
    load_block(2, 1'b1, 0, 256);
    n_checks++; if (bus.load_full !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %b want 1", bus.load_full); end
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.addr_b = 8'(i);
      tick();
      n_checks++;
      if (bus.pix_data !== (8'(i) ^ 8'h5A)) begin n_fail++; $display("FAIL bp_read: addr %h got %h want %h", i, bus.pix_data, 8'(i) ^ 8'h5A); end
    end
  endtask

  task automatic test_mid_load_reset();
    load_block(3, 1'b0, 0, 100);
    n_checks++; if (bus.load_full !== 1'b0) begin n_fail++; $display("FAIL mr_partial_full: got %b want 0", bus.load_full); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.front_valid !== 1'b0) begin n_fail++; $display("FAIL mr_fv: got %b want 0", bus.front_valid); end
    n_checks++; if (bus.pix_data !== 8'h0) begin n_fail++; $display("FAIL mr_pix: got %h want 0", bus.pix_data); end
    n_checks++; if (bus.quad_data !== 32'h0) begin n_fail++; $display("FAIL mr_quad: got %h want 0", bus.quad_data); end
    tick();
    rst_n = 1'b1;
    tick();
    load_block(4, 1'b0, 0, 255);
    n_checks++; if (bus.load_full !== 1'b0) begin n_fail++; $display("FAIL mr_reload_early_full: got %b want 0", bus.load_full); end
    load_block(4, 1'b0, 255, 1);
    n_checks++; if (bus.load_full !== 1'b1) begin n_fail++; $display("FAIL mr_reload_full: got %b want 1", bus.load_full); end
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.addr_b = 8'(i);
      tick();
      n_checks++;
      if (bus.pix_data !== 8'(i + 3)) begin n_fail++; $display("FAIL mr_read: addr %h got %h want %h", i, bus.pix_data, 8'(i + 3)); end
    end
    bus.addr_a = 7'd5;
    tick();
    n_checks++; if (bus.quad_data !== 32'h0D0E1D1E) begin n_fail++; $display("FAIL mr_quad_5: got %h want 0d0e1d1e", bus.quad_data); end
  endtask

  initial begin
    test_reset();
    test_full_load_swap();
    test_pixel_read();
    test_quad_read();
    test_ping_pong();
    test_backpressure();
    test_mid_load_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_pixel_buffer.md
# banked_pixel_buffer

Parametrised, double-buffered, bank-interleaved pixel block memory for the motion-estimation datapath. It replaces a fixed 2x2-bank, 16x16 read-only template store with a generalised block. A valid/ready write stream loads one block in raster order into the back buffer. A swap pulse promotes the back buffer to front. Two read ports serve the front buffer: a quad port returns a BX x BY pixel neighbourhood per cycle to the SAD array, and a pixel port returns single pixels addressed in raster order.

## Interface
Parameters:
- DWIDTH, 8: pixel width in bits.
- BLK_W, 16: block width in pixels. Power of 2.
- BLK_H, 16: block height in pixels. Power of 2.
- BX, 2: horizontal bank interleave. Power of 2, divides BLK_W.
- BY, 2: vertical bank interleave. Power of 2, divides BLK_H.
- Derived: NB = BX*BY; QAW = log2(BLK_W*BLK_H/NB); PAW = log2(BLK_W*BLK_H).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write pixel valid.
- wr_ready  out  1  back buffer can accept a pixel.
- wr_data  in  DWIDTH  write pixel.
- swap  in  1  single-cycle request to promote the back buffer.
- load_full  out  1  back buffer holds a complete block.
- front_valid  out  1  front buffer holds a complete block.
- addr_a  in  QAW  quad read address.
- quad_data  out  NB*DWIDTH  quad read data; bank 0 in the MSBs.
- addr_b  in  PAW  pixel read address {y, x}.
- pix_data  out  DWIDTH  pixel read data.

## Operation
- Pixel (x, y) lives in bank k = (y mod BY)*BX + (x mod BX), at word w = (y/BY)*(BLK_W/BX) + x/BX.
- Each bank is one array of depth 2*BLK_W*BLK_H/NB. The word address MSB is the buffer select bit. Memory contents are never reset.
- Write: a pixel is accepted when wr_valid and wr_ready are both high. The raster counter p (PAW bits) gives x = p mod BLK_W and y = p / BLK_W. The pixel is written to the back buffer (buffer bit = !front_sel) and p increments.
- When the pixel at p = BLK_W*BLK_H-1 is accepted, load_full sets and p wraps to 0.
- wr_ready = !load_full. Writes are never accepted while the back buffer is full.
- Swap: a swap pulse with load_full=1 does the following on the same edge: toggles front_sel, clears load_full, and sets front_valid. A swap pulse with load_full=0 is ignored with no state change.
- Quad read: the banks are read at word addr_a of the front buffer. Bank k's output goes to quad_data[(NB-k)*DWIDTH-1 -: DWIDTH].
- Pixel read: addr_b is decoded to its bank and word as above. All banks are read. The bank index is registered alongside the RAM read and selects pix_data, so the select always stays aligned with the returned data.
- Reads are unconditional every cycle. Both read ports may target the same bank and word simultaneously.
- Reads and writes never conflict, because they address opposite buffers.

## Timing
- Reset values: wr_ready=1, load_full=0, front_valid=0, quad_data=0, pix_data=0, front_sel=0, p=0.
- Read latency is 1 cycle on both ports. Data for the address sampled at edge n is valid after edge n+1.
- quad_data and pix_data come from output registers and are stable for the full cycle.
- Write throughput is 1 pixel/cycle. A full block takes BLK_W*BLK_H accepted beats.
- Last beat at edge n: load_full=1 and wr_ready=0 from edge n onward.
- Swap at edge m (with load_full=1): wr_ready=1 after m. A read sampled at edge m uses the old front buffer. A read sampled at edge m+1 uses the new front buffer.
- wr_valid with wr_ready=0: no write, p is unchanged, and no error is flagged.
- Swap asserted for several cycles: only the first cycle with load_full=1 acts. The following cycles see load_full=0 and are ignored.
- Reset asserted mid-load: p=0 and load_full=0 immediately. The partial block is discarded, and the next load restarts at pixel 0.
- Before the first swap, read data is undefined memory content. Consumers must gate on front_valid.

## Test plan
Common setup: DWIDTH=8, BLK_W=BLK_H=16, BX=BY=2.
- Reset: assert rst_n=0 mid-cycle -> all outputs at reset values immediately, wr_ready=1, front_valid=0.
- Full load and swap: write pixels 0..255 with value = index, wr_valid held high -> wr_ready drops after beat 256, load_full=1. Pulse swap -> front_valid=1 and wr_ready=1 on the next cycle.
- Pixel read: addr_b=8'h13 -> pix_data=8'h13 one cycle later. Then addr_b changes every cycle over 0x00..0xFF -> each pix_data equals the address from the previous cycle, confirming aligned bank select.
- Quad read: addr_a=5 -> quad_data=32'h0A0B1A1B one cycle later. addr_a=63 -> quad_data=32'hEEEFFEFF.
- Ping-pong: load a second block with value = 255-index while reading the front -> front reads stay unchanged. Swap with reads active -> the read issued in the swap cycle returns the old value and the next read returns the new value. Swap with load_full=0 -> no change.
- Backpressure and mid-load reset: throttle wr_valid randomly for a full load -> contents correct. Reset after 100 beats, then reload -> p restarts at 0 and contents are correct.
